// File: rtl/simple_spi_master.sv
// SPI mode-0 master: one full-duplex, MSB-first WIDTH-bit transfer per start,
// framed by pin_ncs, with pin_clk divided down from system_clk.
module simple_spi_master #(
    parameter int WIDTH    = 8,
    parameter int CLKDIV   = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic             system_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic             busy,
    output logic             done,
    output logic             pin_ncs,
    output logic             pin_clk,
    output logic             pin_mosi,
    input  logic             pin_miso
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(CLKDIV, CS_SETUP), max_of(CS_HOLD, CS_IDLE));
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [BIT_W-1:0] r_bit,   w_bit;
    logic [WIDTH-1:0] r_tx,    w_tx;
    logic [WIDTH-1:0] r_rx,    w_rx;
    logic [WIDTH-1:0] r_value_miso, w_value_miso;
    logic             r_busy,  w_busy;
    logic             r_done,  w_done;
    logic             r_ncs,   w_ncs;
    logic             r_clk,   w_clk;
    logic             r_mosi,  w_mosi;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path can leave one unassigned and infer a latch.
        w_state      = r_state;
        w_cnt        = r_cnt + CNT_W'(1);
        w_bit        = r_bit;
        w_tx         = r_tx;
        w_rx         = r_rx;
        w_value_miso = r_value_miso;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_ncs        = r_ncs;
        w_clk        = r_clk;
        w_mosi       = r_mosi;

        unique case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (start) begin
                    w_tx    = value_mosi;
                    w_rx    = '0;
                    w_bit   = '0;
                    w_ncs   = 1'b0;
                    w_mosi  = value_mosi[WIDTH-1];
                    w_busy  = 1'b1;
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                    w_cnt   = '0;
                    w_state = S_LOW;
                end
            end
            S_LOW: begin
                if (r_cnt == CNT_W'(CLKDIV - 1)) begin
                    w_cnt   = '0;
                    w_clk   = 1'b1;
                    w_state = S_HIGH;
                end
            end
            S_HIGH: begin
                // Sampling on the last HIGH cycle leaves CLKDIV-1 cycles of slave settling margin.
                if (r_cnt == CNT_W'(CLKDIV - 1)) begin
                    w_cnt = '0;
                    w_clk = 1'b0;
                    w_rx  = {r_rx[WIDTH-2:0], pin_miso};
                    if (r_bit == BIT_W'(WIDTH - 1)) begin
                        w_state = S_HOLD;
                    end else begin
                        w_bit   = r_bit + BIT_W'(1);
                        w_tx    = {r_tx[WIDTH-2:0], 1'b0};
                        w_mosi  = r_tx[WIDTH-2];
                        w_state = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
                    w_cnt        = '0;
                    w_ncs        = 1'b1;
                    w_mosi       = 1'b0;
                    w_value_miso = r_rx;
                    w_done       = 1'b1;
                    w_state      = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(CS_IDLE - 1)) begin
                    w_cnt   = '0;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_value_miso <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ncs        <= 1'b1;
            r_clk        <= 1'b0;
            r_mosi       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_bit        <= w_bit;
            r_tx         <= w_tx;
            r_rx         <= w_rx;
            r_value_miso <= w_value_miso;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_ncs        <= w_ncs;
            r_clk        <= w_clk;
            r_mosi       <= w_mosi;
        end
    end

    assign value_miso = r_value_miso;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pin_ncs    = r_ncs;
    assign pin_clk    = r_clk;
    assign pin_mosi   = r_mosi;

endmodule

// File: tb/tb_simple_spi_master.sv
// Bench for simple_spi_master: cycle-offset waveform model checked every cycle,
// plus directed transfers with hand-computed expected words and timings.
module tb_simple_spi_master;

    localparam int WIDTH    = 8;
    localparam int CLKDIV   = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;
    localparam int L        = CS_SETUP + 2 * CLKDIV * WIDTH + CS_HOLD;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       start      = 1'b0;
    logic [7:0] value_mosi = 8'h00;
    logic [7:0] value_miso;
    logic       busy, done, pin_ncs, pin_clk, pin_mosi, pin_miso;

    int n_checks = 0;
    int n_errors = 0;

    simple_spi_master #(
        .WIDTH(WIDTH), .CLKDIV(CLKDIV), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) dut (
        .system_clk(clk),
        .rst(rst),
        .start(start),
        .value_mosi(value_mosi),
        .value_miso(value_miso),
        .busy(busy),
        .done(done),
        .pin_ncs(pin_ncs),
        .pin_clk(pin_clk),
        .pin_mosi(pin_mosi),
        .pin_miso(pin_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave side: 0 loopback, 1 shift-register slave, 2 tied high, 3 tied low.
    int         mode       = 0;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] s_sh       = 8'h00;
    logic [7:0] s_rx       = 8'h00;
    logic       prev_ncs   = 1'b1;
    logic       prev_clk   = 1'b0;
    int         rises      = 0;
    int         dones      = 0;
    logic       rst_q      = 1'b1;
    logic       start_q    = 1'b0;
    logic [7:0] vm_q       = 8'h00;

    assign pin_miso = (mode == 0) ? pin_mosi : (mode == 1) ? s_sh[7] : (mode == 2);

    always @(posedge clk) begin
        rst_q    <= rst;
        start_q  <= start;
        vm_q     <= value_mosi;
        prev_ncs <= pin_ncs;
        prev_clk <= pin_clk;
        if (done === 1'b1) dones <= dones + 1;
        if (prev_ncs && !pin_ncs) begin
            s_sh <= slave_word;
            s_rx <= 8'h00;
        end else begin
            if (prev_clk && !pin_clk) s_sh <= {s_sh[6:0], 1'b0};
            if (!prev_clk && pin_clk && !pin_ncs) begin
                rises <= rises + 1;
                s_rx  <= {s_rx[6:0], pin_mosi};
            end
        end
    end

    // Model: n counts edges since the accepting edge (0 = idle); outputs follow from n by arithmetic.
    int         mn = 0;
    int         mm, mb;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00, m_vm = 8'h00;
    logic       e_ncs, e_clk, e_mosi, e_busy, e_done;

    initial forever begin
        @(negedge clk);
        if (rst_q) begin
            mn   = 0;
            m_vm = 8'h00;
        end else if (mn == 0) begin
            if (start_q) begin
                mn   = 1;
                m_tx = vm_q;
                m_rx = (mode == 0) ? vm_q : (mode == 1) ? slave_word : (mode == 2) ? 8'hFF : 8'h00;
            end
        end else begin
            mn++;
            if (mn == L + CS_IDLE + 1) mn = 0;
        end
        if (mn == L + 1) m_vm = m_rx;

        mm     = mn - CS_SETUP - 1;
        mb     = (mm < 0) ? 0 : mm / (2 * CLKDIV);
        if (mb > WIDTH - 1) mb = WIDTH - 1;
        e_ncs  = !(mn >= 1 && mn <= L);
        e_clk  = !e_ncs && mm >= 0 && mm < 2 * CLKDIV * WIDTH && (mm % (2 * CLKDIV)) >= CLKDIV;
        e_mosi = !e_ncs && m_tx[WIDTH-1-mb];
        e_busy = (mn >= 1);
        e_done = (mn == L + 1);

        check("model_ncs", pin_ncs, e_ncs);
        check("model_clk", pin_clk, e_clk);
        check("model_mosi", pin_mosi, e_mosi);
        check("model_busy", busy, e_busy);
        check("model_done", done, e_done);
        check("model_value_miso", value_miso, m_vm);
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && busy !== 1'b0; i++) begin
            @(posedge clk);
            #1;
        end
        if (busy !== 1'b0) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    task automatic run_xfer(input logic [7:0] w);
        wait_idle();
        start      = 1'b1;
        value_mosi = w;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
    endtask

    logic [7:0] m_vec [13];
    logic [7:0] s_vec [13];

    initial begin
        int r0, d0, hi, k_clk, k_done, k_idle;
        m_vec = '{8'h66, 8'hEE, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'h3C, 8'h12, 8'hDE, 8'h7F, 8'hA5, 8'h0F};
        s_vec = '{8'hAA, 8'hEE, 8'hFF, 8'h00, 8'h80, 8'h01, 8'hAA, 8'hC3, 8'h34, 8'hAD, 8'hFE, 8'h5A, 8'hF0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ncs", pin_ncs, 1);
        check("reset_clk", pin_clk, 0);
        check("reset_mosi", pin_mosi, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_value_miso", value_miso, 8'h00);

        // Loopback of A5: exactly eight SPI clock rises, one done.
        mode = 0;
        r0 = rises;
        d0 = dones;
        run_xfer(8'hA5);
        check("loop_value_miso", value_miso, 8'hA5);
        wait_idle();
        check("loop_rises", rises - r0, 8);
        check("loop_dones", dones - d0, 1);

        // Timing from the accepting edge (k = 0), sampled 1 ns after each edge.
        wait_idle();
        start      = 1'b1;
        value_mosi = 8'h96;
        @(posedge clk);
        #1 start = 1'b0;
        check("timing_ncs_low_k0", pin_ncs, 0);
        k_clk = -1; k_done = -1; k_idle = -1;
        for (int k = 1; k <= 120 && k_idle < 0; k++) begin
            @(posedge clk);
            #1;
            if (pin_clk === 1'b1 && k_clk < 0) k_clk = k;
            if (done === 1'b1 && k_done < 0) k_done = k;
            if (busy === 1'b0 && k_idle < 0) k_idle = k;
        end
        check("timing_first_clk", k_clk, 6);
        check("timing_done", k_done, 68);
        check("timing_busy_low", k_idle, 72);

        // Paired with a shift-register slave: both directions must arrive intact.
        mode = 1;
        for (int i = 0; i < 13; i++) begin
            wait_idle();
            slave_word = s_vec[i];
            run_xfer(m_vec[i]);
            check("pair_value_miso", value_miso, s_vec[i]);
            check("pair_slave_rx", s_rx, m_vec[i]);
        end

        // Tied pin_miso.
        wait_idle();
        mode = 2;
        run_xfer(8'h00);
        check("tie1_value_miso", value_miso, 8'hFF);
        wait_idle();
        mode = 3;
        run_xfer(8'h00);
        check("tie0_value_miso", value_miso, 8'h00);

        // Reset after the third SPI clock rise aborts the transfer.
        wait_idle();
        mode = 0;
        r0 = rises;
        d0 = dones;
        start      = 1'b1;
        value_mosi = 8'hC6;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100 && rises - r0 < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort_saw_three_rises", rises - r0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_ncs", pin_ncs, 1);
        check("abort_clk", pin_clk, 0);
        check("abort_busy", busy, 0);
        check("abort_mosi", pin_mosi, 0);
        repeat (100) @(posedge clk);
        #1;
        check("abort_no_done", dones - d0, 0);
        check("abort_value_miso", value_miso, 8'h00);
        run_xfer(8'h3C);
        check("after_abort_value_miso", value_miso, 8'h3C);

        // Start pulses while busy are ignored.
        wait_idle();
        d0 = dones;
        start      = 1'b1;
        value_mosi = 8'h5A;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            start      = (k == 10 || k == 40);
            value_mosi = (k == 10 || k == 40) ? 8'hFF : 8'h5A;
        end
        start = 1'b0;
        wait_idle();
        check("ignored_start_dones", dones - d0, 1);
        check("ignored_start_value_miso", value_miso, 8'h5A);

        // Held start: back-to-back transfers with a fixed pin_ncs high gap.
        start      = 1'b1;
        value_mosi = 8'h81;
        wait_done();
        hi = 0;
        while (pin_ncs === 1'b1 && hi < 50) begin
            hi++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("b2b_ncs_high_cycles", hi, 5);
        wait_done();
        check("b2b_value_miso", value_miso, 8'h81);
        wait_idle();
        check("b2b_dones", dones - d0, 3);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
